// File: rtl/weight_load_ctrl_pkg.sv
// Shared configuration for the weight load controller: widths and FSM state type.
package weight_load_ctrl_pkg;

  localparam int WL_SYS_COLS       = 3;
  localparam int WL_W_BUFFER_DEPTH = 16;
  localparam int WL_ROW_W          = $clog2(WL_W_BUFFER_DEPTH + 1);
  localparam int WL_TILE_W         = 8;

  typedef enum logic [2:0] {
    WL_IDLE,
    WL_WAIT_RDY,
    WL_READ,
    WL_DRAIN,
    WL_FIN
  } wl_state_t;

endpackage

// File: rtl/weight_load_ctrl_if.sv
// Scheduler/array-facing bundle of the weight load controller.
interface weight_load_ctrl_if
  import weight_load_ctrl_pkg::*;
#(
  parameter int ROW_W  = WL_ROW_W,
  parameter int TILE_W = WL_TILE_W
);

  logic              start;
  logic [ROW_W-1:0]  num_rows;
  logic [TILE_W-1:0] num_tiles;
  logic              array_ready;
  logic              read;
  logic              busy;
  logic              tile_done;
  logic              done;
  logic              err;
  logic [TILE_W-1:0] tile_idx;

  modport master (
    output start, num_rows, num_tiles, array_ready,
    input  read, busy, tile_done, done, err, tile_idx
  );

  modport slave (
    input  start, num_rows, num_tiles, array_ready,
    output read, busy, tile_done, done, err, tile_idx
  );

endinterface

// File: rtl/weight_load_ctrl.sv
// Issues per-tile read bursts into the skewed weight buffer and waits out the
// column skew so every column holds the tile before tile_done is raised.
module weight_load_ctrl
  import weight_load_ctrl_pkg::*;
#(
  parameter int COLS   = WL_SYS_COLS,
  parameter int DEPTH  = WL_W_BUFFER_DEPTH,
  parameter int ROW_W  = $clog2(DEPTH + 1),
  parameter int TILE_W = WL_TILE_W
) (
  input  logic clk,
  input  logic rst,
  weight_load_ctrl_if.slave bus
);

  localparam int DW = $clog2(COLS + 1);
  localparam int PW = ROW_W + TILE_W;

  wl_state_t         state;
  wl_state_t         state_next;
  logic [ROW_W-1:0]  rows_q;
  logic [TILE_W-1:0] tiles_q;
  logic [ROW_W-1:0]  row_cnt;
  logic [DW-1:0]     drain_cnt;
  logic [TILE_W-1:0] tile_idx;
  logic              err;

  logic [PW-1:0]     prod;
  logic              too_big;
  logic              empty_job;
  logic              more_tiles;
  logic              last_row;
  logic              last_drain;
  logic              read;
  logic              busy;
  logic              tile_done;
  logic              done;

  // The size check uses the full-width product so an oversized job can never alias to a small one.
  assign prod       = PW'(bus.num_rows) * PW'(bus.num_tiles);
  assign too_big    = prod > PW'(DEPTH);
  assign empty_job  = (bus.num_rows == '0) || (bus.num_tiles == '0);
  assign more_tiles = ({1'b0, tile_idx} + 1'b1) < {1'b0, tiles_q};

  // State register; reset wins over everything, including an in-flight burst.
  always_ff @(posedge clk) begin
    if (rst) state <= WL_IDLE;
    else     state <= state_next;
  end

  // Next-state decode and Moore-style outputs straight from the state and counters.
  always_comb begin
    state_next = state;
    read       = 1'b0;
    busy       = 1'b1;
    tile_done  = 1'b0;
    done       = 1'b0;
    last_row   = 1'b0;
    last_drain = 1'b0;
    case (state)
      WL_IDLE: begin
        busy = 1'b0;
        if (bus.start) begin
          if (too_big || empty_job) state_next = WL_FIN;
          else                      state_next = WL_WAIT_RDY;
        end
      end
      WL_WAIT_RDY: begin
        if (bus.array_ready) state_next = WL_READ;
      end
      WL_READ: begin
        read = 1'b1;
        if (row_cnt == rows_q - ROW_W'(1)) begin
          last_row   = 1'b1;
          state_next = WL_DRAIN;
        end
      end
      WL_DRAIN: begin
        if (drain_cnt == DW'(1)) begin
          last_drain = 1'b1;
          tile_done  = 1'b1;
          state_next = more_tiles ? WL_WAIT_RDY : WL_FIN;
        end
      end
      WL_FIN: begin
        busy       = 1'b0;
        done       = 1'b1;
        state_next = WL_IDLE;
      end
      default: state_next = WL_IDLE;
    endcase
  end

  // Job latches, row/drain/tile counters and the sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      rows_q    <= '0;
      tiles_q   <= '0;
      row_cnt   <= '0;
      drain_cnt <= '0;
      tile_idx  <= '0;
      err       <= 1'b0;
    end else begin
      case (state)
        WL_IDLE: begin
          if (bus.start) begin
            rows_q   <= bus.num_rows;
            tiles_q  <= bus.num_tiles;
            err      <= too_big;
            row_cnt  <= '0;
            tile_idx <= '0;
          end
        end
        WL_READ: begin
          if (last_row) begin
            row_cnt   <= '0;
            drain_cnt <= DW'(COLS);
          end else begin
            row_cnt <= row_cnt + ROW_W'(1);
          end
        end
        WL_DRAIN: begin
          drain_cnt <= drain_cnt - DW'(1);
          if (last_drain) begin
            if (more_tiles) tile_idx <= tile_idx + TILE_W'(1);
            else            tile_idx <= '0;
          end
        end
        WL_FIN: tile_idx <= '0;
        default: ;
      endcase
    end
  end

  assign bus.read      = read;
  assign bus.busy      = busy;
  assign bus.tile_done = tile_done;
  assign bus.done      = done;
  assign bus.err       = err;
  assign bus.tile_idx  = tile_idx;

endmodule

// File: tb/tb_weight_load_ctrl.sv
// Self-checking bench for weight_load_ctrl (COLS=3, DEPTH=16) using a timeline model.
module tb_weight_load_ctrl;
  import weight_load_ctrl_pkg::*;

  localparam int COLS  = 3;
  localparam int DEPTH = 16;
  localparam int MAXC  = 256;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   cyc;
  logic model_err;

  bit       rdy     [0:MAXC-1];
  bit       e_read  [0:MAXC-1];
  bit       e_busy  [0:MAXC-1];
  bit       e_tdone [0:MAXC-1];
  bit       e_done  [0:MAXC-1];
  int       e_tidx  [0:MAXC-1];

  weight_load_ctrl_if bus_if ();

  weight_load_ctrl #(
    .COLS  (COLS),
    .DEPTH (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_stimulus(input logic s, input logic [4:0] r, input logic [7:0] t,
                                input logic a);
    bus_if.start       = s;
    bus_if.num_rows    = r;
    bus_if.num_tiles   = t;
    bus_if.array_ready = a;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Builds the expected per-cycle trace of one job from the ready pattern in rdy[].
  task automatic build_model(input int rows, input int tiles, output int n, output int nreads);
    int t;
    for (int c = 0; c < MAXC; c++) begin
      e_read[c] = 0; e_busy[c] = 0; e_tdone[c] = 0; e_done[c] = 0; e_tidx[c] = 0;
    end
    if (rows * tiles > DEPTH || rows == 0 || tiles == 0) begin
      e_done[1] = 1;
      n = 3;
      nreads = 0;
      return;
    end
    nreads = rows * tiles;
    t = 1;
    for (int k = 0; k < tiles; k++) begin
      while (!rdy[t] && t < MAXC - 40) begin
        e_busy[t] = 1; e_tidx[t] = k; t++;
      end
      e_busy[t] = 1; e_tidx[t] = k;
      for (int r = 1; r <= rows; r++) begin
        e_read[t + r] = 1; e_busy[t + r] = 1; e_tidx[t + r] = k;
      end
      for (int j = 1; j <= COLS; j++) begin
        e_busy[t + rows + j] = 1; e_tidx[t + rows + j] = k;
      end
      e_tdone[t + rows + COLS] = 1;
      t = t + rows + COLS + 1;
    end
    e_done[t] = 1;
    n = t + 2;
  endtask

  // mode 0: ready always high; 1: random ready; 2: ready low for cycles 8..12
  task automatic run_job(input int rows, input int tiles, input int mode, input bit noise);
    int  n;
    int  exp_reads;
    int  nreads;
    logic new_err;
    logic s;
    for (int c = 0; c < MAXC; c++) begin
      case (mode)
        0:       rdy[c] = 1;
        1:       rdy[c] = ($urandom_range(0, 1) == 1) || (c % 8 == 7);
        default: rdy[c] = !(c >= 8 && c <= 12);
      endcase
    end
    build_model(rows, tiles, n, exp_reads);
    new_err = (rows * tiles > DEPTH);
    nreads = 0;
    for (int c = 0; c < n; c++) begin
      cyc = c;
      if (c == 0) s = 1'b1;
      else        s = noise && (e_busy[c] || e_done[c]) && ($urandom_range(0, 1) == 1);
      if (c == 0) apply_stimulus(s, 5'(rows), 8'(tiles), rdy[c]);
      else        apply_stimulus(s, 5'($urandom), 8'($urandom), rdy[c]);
      @(negedge clk);
      if (bus_if.read === 1'b1) nreads++;
      check_output("read", 32'(bus_if.read), 32'(e_read[c]));
      check_output("busy", 32'(bus_if.busy), 32'(e_busy[c]));
      check_output("tile_done", 32'(bus_if.tile_done), 32'(e_tdone[c]));
      check_output("done", 32'(bus_if.done), 32'(e_done[c]));
      check_output("err", 32'(bus_if.err), 32'(c == 0 ? model_err : new_err));
      check_output("tile_idx", 32'(bus_if.tile_idx), 32'(e_tidx[c]));
      @(posedge clk);
      #1;
    end
    model_err = new_err;
    check_output("read_count", 32'(nreads), 32'(exp_reads));
  endtask

  initial begin
    int rows;
    int tiles;
    total = 0;
    bad = 0;
    cyc = 0;
    model_err = 1'b0;
    rst = 1'b1;
    apply_stimulus(1'b0, 5'd0, 8'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check_output("rst_read", 32'(bus_if.read), 32'd0);
    check_output("rst_busy", 32'(bus_if.busy), 32'd0);
    check_output("rst_tile_done", 32'(bus_if.tile_done), 32'd0);
    check_output("rst_done", 32'(bus_if.done), 32'd0);
    check_output("rst_err", 32'(bus_if.err), 32'd0);
    check_output("rst_tile_idx", 32'(bus_if.tile_idx), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] single tile, ready high");
    run_job(4, 1, 0, 1'b0);
    $display("[TB] two tiles, ready gap between tiles");
    run_job(3, 2, 2, 1'b0);
    $display("[TB] oversized job then legal job");
    run_job(5, 4, 0, 1'b0);
    run_job(2, 2, 0, 1'b0);
    $display("[TB] empty job");
    run_job(0, 3, 0, 1'b0);
    $display("[TB] start noise while busy");
    run_job(4, 2, 1, 1'b1);
    $display("[TB] capacity boundaries");
    run_job(16, 1, 1, 1'b0);
    run_job(4, 4, 0, 1'b0);
    run_job(17, 1, 0, 1'b0);
    run_job(16, 16, 0, 1'b0);
    run_job(1, 16, 1, 1'b0);

    $display("[TB] reset during a burst");
    for (int c = 0; c < 13; c++) begin
      cyc = c;
      apply_stimulus(c == 0, 5'd4, 8'd1, 1'b1);
      rst = (c == 3);
      @(negedge clk);
      if (c == 2 || c == 3) check_output("mid_read", 32'(bus_if.read), 32'd1);
      if (c >= 4) begin
        check_output("post_rst_read", 32'(bus_if.read), 32'd0);
        check_output("post_rst_done", 32'(bus_if.done), 32'd0);
        check_output("post_rst_busy", 32'(bus_if.busy), 32'd0);
        check_output("post_rst_tile_idx", 32'(bus_if.tile_idx), 32'd0);
      end
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    model_err = 1'b0;
    run_job(4, 1, 0, 1'b0);

    $display("[TB] random jobs");
    for (int j = 0; j < 20; j++) begin
      case ($urandom_range(0, 4))
        0: begin
          rows = 0;
          tiles = $urandom_range(0, 255);
        end
        1: begin
          rows = $urandom_range(1, 31);
          tiles = $urandom_range(DEPTH / rows + 1, 255);
        end
        default: begin
          rows = $urandom_range(1, 16);
          tiles = $urandom_range(1, DEPTH / rows);
        end
      endcase
      run_job(rows, tiles, 1, ($urandom_range(0, 1) == 1));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
